// File: rtl/ipm_distributed_sync_fifo_v2_0.sv
// ipm_distributed_sync_fifo_v2_0
// Single-clock FIFO on distributed RAM with standard or first-word-fall-through
// read, write-when-full with simultaneous read, synchronous flush and rd_valid.
// Optional sticky overflow/underflow flags: define IPM_DIST_FIFO_ERR_FLAG_EN.
module ipm_distributed_sync_fifo_v2_0 #(
    parameter int ADDR_WIDTH       = 5,
    parameter int DATA_WIDTH       = 32,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = 4,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF    = (ADDR_WIDTH+1)'(DEPTH - ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0]   CNT_AE    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  rd_acc;
    logic                  wr_acc;

    // A write at full is only safe when a read frees the slot in the same cycle;
    // reads at empty never bypass a same-cycle write.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_en);

    // Status outputs are pure decodes of the registered count.
    assign full         = (count == CNT_DEPTH);
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);
    assign water_level  = count;

    // Storage write port; no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; flush drops contents but keeps the RAM as is.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            // Registered read: one-cycle latency, rd_data holds between reads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else if (flush) begin
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc)
                        rd_data <= mem[rd_ptr];
                end
            end
        end else begin : g_fwft
            // Head word is shown directly; zero while nothing is stored.
            assign rd_data  = empty ? '0 : mem[rd_ptr];
            assign rd_valid = ~empty;
        end
    endgenerate

`ifdef IPM_DIST_FIFO_ERR_FLAG_EN
    // Sticky error flags; a new refusal wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc && !flush) overflow <= 1'b1;
            else if (err_clr)               overflow <= 1'b0;
            if (rd_en && empty && !flush)   underflow <= 1'b1;
            else if (err_clr)               underflow <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_ipm_distributed_sync_fifo_v2_0.sv
// Bench for ipm_distributed_sync_fifo_v2_0: a standard-read and an FWFT instance
// share one stimulus stream and are checked against a queue-based model.
module tb_ipm_distributed_sync_fifo_v2_0;
    localparam int AW = 4, DW = 8, DEPTH = 16, AFN = 4, AEN = 4;
`ifdef IPM_DIST_FIFO_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, flush, wr_en, rd_en, err_clr;
    logic [DW-1:0] wr_data;

    logic          full_a, af_a, empty_a, ae_a, vld_a, ov_a, un_a;
    logic [DW-1:0] rdd_a;
    logic [AW:0]   wl_a;
    logic          full_b, af_b, empty_b, ae_b, vld_b, ov_b, un_b;
    logic [DW-1:0] rdd_b;
    logic [AW:0]   wl_b;

    int total = 0;
    int bad   = 0;

    // behavioural model
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd;
    bit            m_vld, m_ov, m_un;

    always #5 clk = ~clk;

    ipm_distributed_sync_fifo_v2_0 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0),
        .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .full(full_a), .almost_full(af_a), .rd_en(rd_en), .rd_data(rdd_a),
        .rd_valid(vld_a), .empty(empty_a), .almost_empty(ae_a), .water_level(wl_a),
        .overflow(ov_a), .underflow(un_a), .err_clr(err_clr));

    ipm_distributed_sync_fifo_v2_0 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1),
        .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .full(full_b), .almost_full(af_b), .rd_en(rd_en), .rd_data(rdd_b),
        .rd_valid(vld_b), .empty(empty_b), .almost_empty(ae_b), .water_level(wl_b),
        .overflow(ov_b), .underflow(un_b), .err_clr(err_clr));

    function automatic logic [DW-1:0] head();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    // Drive one clock of inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input bit r, input bit w, input logic [DW-1:0] d,
                         input bit rd, input bit fl, input bit clr);
        bit was_full, was_empty, racc, wacc, set_ov, set_un;
        rst = r; wr_en = w; wr_data = d; rd_en = rd; flush = fl; err_clr = clr;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (r) begin
            q.delete(); m_rd = '0; m_vld = 0; m_ov = 0; m_un = 0;
        end else if (fl) begin
            q.delete(); m_vld = 0;
            if (clr) begin m_ov = 0; m_un = 0; end
        end else begin
            racc = rd && !was_empty;
            wacc = w && (!was_full || rd);
            m_vld = racc;
            if (racc) m_rd = q.pop_front();
            if (wacc) q.push_back(d);
            set_ov = ERR_EN && w && !wacc;
            set_un = ERR_EN && rd && was_empty;
            m_ov = set_ov ? 1'b1 : (clr ? 1'b0 : m_ov);
            m_un = set_un ? 1'b1 : (clr ? 1'b0 : m_un);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 8'h00, 0, 0, 0);
        cycle(1, 1, 8'h33, 1, 0, 1);
        total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty_a); end
        total++; if (ae_a !== 1'b1) begin bad++; $display("FAIL rst_almost_empty got=%b exp=1", ae_a); end
        total++; if (full_a !== 1'b0 || af_a !== 1'b0) begin bad++; $display("FAIL rst_full got=%b/%b exp=0/0", full_a, af_a); end
        total++; if (wl_a !== '0) begin bad++; $display("FAIL rst_level got=%0d exp=0", wl_a); end
        total++; if (rdd_a !== '0 || vld_a !== 1'b0) begin bad++; $display("FAIL rst_rd_std got=%h/%b exp=00/0", rdd_a, vld_a); end
        total++; if (rdd_b !== '0 || vld_b !== 1'b0) begin bad++; $display("FAIL rst_rd_fwft got=%h/%b exp=00/0", rdd_b, vld_b); end
        total++; if (ov_a !== 1'b0 || un_a !== 1'b0) begin bad++; $display("FAIL rst_err got=%b/%b exp=0/0", ov_a, un_a); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, DW'(i), 0, 0, 0);
            total++; if (wl_a !== (AW+1)'(q.size())) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", wl_a, q.size()); end
            total++; if (af_a !== (q.size() >= DEPTH-AFN)) begin bad++; $display("FAIL fill_almost_full lvl=%0d got=%b", q.size(), af_a); end
            total++; if (full_a !== (q.size() == DEPTH)) begin bad++; $display("FAIL fill_full lvl=%0d got=%b", q.size(), full_a); end
        end
        cycle(0, 1, 8'hEE, 0, 0, 0);
        total++; if (full_a !== 1'b1 || wl_a !== 5'd16) begin bad++; $display("FAIL drop_write got=%b/%0d exp=1/16", full_a, wl_a); end
        total++; if (ov_a !== m_ov || un_a !== 1'b0) begin bad++; $display("FAIL drop_overflow got=%b/%b exp=%b/0", ov_a, un_a, m_ov); end
    endtask

    task automatic test_full_rw();
        cycle(0, 1, 8'hAA, 1, 0, 0);
        total++; if (rdd_a !== 8'h00 || vld_a !== 1'b1) begin bad++; $display("FAIL full_rw_data got=%h/%b exp=00/1", rdd_a, vld_a); end
        total++; if (full_a !== 1'b1 || wl_a !== 5'd16) begin bad++; $display("FAIL full_rw_full got=%b/%0d exp=1/16", full_a, wl_a); end
        total++; if (rdd_b !== head()) begin bad++; $display("FAIL full_rw_fwft got=%h exp=%h", rdd_b, head()); end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, 8'h00, 1, 0, 0);
            total++; if (rdd_a !== m_rd || vld_a !== 1'b1) begin bad++; $display("FAIL drain_data got=%h/%b exp=%h/1", rdd_a, vld_a, m_rd); end
        end
        total++; if (rdd_a !== 8'hAA || empty_a !== 1'b1) begin bad++; $display("FAIL drain_last got=%h/%b exp=aa/1", rdd_a, empty_a); end
    endtask

    task automatic test_underflow();
        cycle(0, 0, 8'h00, 1, 0, 0);
        total++; if (vld_a !== 1'b0 || wl_a !== '0) begin bad++; $display("FAIL uf_read got=%b/%0d exp=0/0", vld_a, wl_a); end
        total++; if (un_a !== m_un) begin bad++; $display("FAIL uf_flag got=%b exp=%b", un_a, m_un); end
        cycle(0, 0, 8'h00, 1, 0, 1);
        total++; if (un_a !== m_un) begin bad++; $display("FAIL uf_set_wins got=%b exp=%b", un_a, m_un); end
        cycle(0, 0, 8'h00, 0, 0, 1);
        total++; if (un_a !== 1'b0 || ov_a !== 1'b0) begin bad++; $display("FAIL err_clr got=%b/%b exp=0/0", un_a, ov_a); end
        cycle(0, 1, 8'h3C, 1, 0, 0);
        total++; if (wl_a !== 5'd1 || vld_a !== 1'b0 || un_a !== m_un) begin bad++; $display("FAIL empty_rw got=%0d/%b/%b exp=1/0/%b", wl_a, vld_a, un_a, m_un); end
        cycle(0, 0, 8'h00, 1, 0, 1);
        total++; if (rdd_a !== 8'h3C) begin bad++; $display("FAIL empty_rw_data got=%h exp=3c", rdd_a); end
    endtask

    task automatic test_fwft();
        cycle(0, 1, 8'h55, 0, 0, 0);
        total++; if (empty_b !== 1'b0 || rdd_b !== 8'h55 || vld_b !== 1'b1) begin bad++; $display("FAIL fwft_show got=%b/%h/%b exp=0/55/1", empty_b, rdd_b, vld_b); end
        cycle(0, 0, 8'h00, 1, 0, 0);
        total++; if (empty_b !== 1'b1 || rdd_b !== 8'h00 || vld_b !== 1'b0) begin bad++; $display("FAIL fwft_pop got=%b/%h/%b exp=1/00/0", empty_b, rdd_b, vld_b); end
    endtask

    task automatic test_flush();
        bit ov0, un0;
        logic [DW-1:0] keep;
        logic [DW-1:0] w;
        for (int i = 0; i < 5; i++) cycle(0, 1, DW'($urandom), 0, 0, 0);
        cycle(0, 0, 8'h00, 1, 0, 0);
        keep = m_rd; ov0 = m_ov; un0 = m_un;
        cycle(0, 1, 8'h77, 1, 1, 0);
        total++; if (wl_a !== '0 || empty_a !== 1'b1 || empty_b !== 1'b1) begin bad++; $display("FAIL flush_level got=%0d/%b exp=0/1", wl_a, empty_a); end
        total++; if (vld_a !== 1'b0 || rdd_a !== keep) begin bad++; $display("FAIL flush_rd got=%h/%b exp=%h/0", rdd_a, vld_a, keep); end
        total++; if (ov_a !== ov0 || un_a !== un0) begin bad++; $display("FAIL flush_flags got=%b/%b exp=%b/%b", ov_a, un_a, ov0, un0); end
        w = DW'($urandom);
        cycle(0, 1, w, 0, 0, 0);
        total++; if (rdd_b !== w) begin bad++; $display("FAIL flush_next_fwft got=%h exp=%h", rdd_b, w); end
        cycle(0, 0, 8'h00, 1, 0, 0);
        total++; if (rdd_a !== w || vld_a !== 1'b1) begin bad++; $display("FAIL flush_next_std got=%h/%b exp=%h/1", rdd_a, vld_a, w); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) cycle(0, 1, DW'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, DW'($urandom), 1, 0, 0);
            total++; if (rdd_a !== m_rd || rdd_b !== head() || wl_a !== 5'd3) begin bad++; $display("FAIL wrap_order i=%0d got=%h/%h/%0d exp=%h/%h/3", i, rdd_a, rdd_b, wl_a, m_rd, head()); end
            total++; if (ov_a !== 1'b0 || un_a !== 1'b0) begin bad++; $display("FAIL wrap_flags got=%b/%b exp=0/0", ov_a, un_a); end
        end
        cycle(1, 1, 8'h99, 1, 0, 0);
        total++; if (wl_a !== '0 || empty_a !== 1'b1 || ae_a !== 1'b1 || rdd_a !== '0 || vld_a !== 1'b0 || rdd_b !== '0 || vld_b !== 1'b0)
            begin bad++; $display("FAIL rst_mid got=%0d/%b/%b/%h/%b/%h/%b", wl_a, empty_a, ae_a, rdd_a, vld_a, rdd_b, vld_b); end
    endtask

    task automatic test_random();
        bit w, r, fl, clr;
        for (int i = 0; i < 400; i++) begin
            w   = ($urandom_range(0, 99) < 60);
            r   = ($urandom_range(0, 99) < 45);
            fl  = ($urandom_range(0, 99) < 2);
            clr = ($urandom_range(0, 99) < 5);
            cycle(0, w, DW'($urandom), r, fl, clr);
            total++; if (wl_a !== (AW+1)'(q.size()) || wl_b !== (AW+1)'(q.size())) begin bad++; $display("FAIL rnd_level i=%0d got=%0d/%0d exp=%0d", i, wl_a, wl_b, q.size()); end
            total++; if (full_a !== (q.size() == DEPTH) || empty_a !== (q.size() == 0)) begin bad++; $display("FAIL rnd_full_empty i=%0d got=%b/%b lvl=%0d", i, full_a, empty_a, q.size()); end
            total++; if (af_a !== (q.size() >= DEPTH-AFN) || ae_a !== (q.size() <= AEN)) begin bad++; $display("FAIL rnd_almost i=%0d got=%b/%b lvl=%0d", i, af_a, ae_a, q.size()); end
            total++; if (vld_a !== m_vld || (m_vld && rdd_a !== m_rd)) begin bad++; $display("FAIL rnd_std i=%0d got=%h/%b exp=%h/%b", i, rdd_a, vld_a, m_rd, m_vld); end
            total++; if (rdd_b !== head() || vld_b !== (q.size() != 0)) begin bad++; $display("FAIL rnd_fwft i=%0d got=%h/%b exp=%h", i, rdd_b, vld_b, head()); end
            total++; if (ov_a !== m_ov || un_a !== m_un || ov_b !== m_ov || un_b !== m_un) begin bad++; $display("FAIL rnd_err i=%0d got=%b/%b exp=%b/%b", i, ov_a, un_a, m_ov, m_un); end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
        test_reset();
        test_fill();
        test_full_rw();
        test_underflow();
        test_fwft();
        test_flush();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
